// File: rtl/sreg_tx_arbiter.sv
// Two-requester round-robin scheduler feeding one shared load-and-shift register, MSB first.
// Define SREG_PARITY_EN to append an even-parity bit (PAR state) after the data bits.
`timescale 1ns/1ps
module sreg_tx_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] din0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din1,
  output logic             ack0,
  output logic             ack1,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy,
  output logic             gnt_id
);

  localparam int unsigned    CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

`ifdef SREG_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             last_q,  last_d;
  logic             gnt_q,   gnt_d;
  logic             ack0_q,  ack0_d;
  logic             ack1_q,  ack1_d;
`ifdef SREG_PARITY_EN
  logic             par_q,   par_d;
`endif

  logic             win;
  logic [WIDTH-1:0] win_din;

  // On a tie the requester that was not served last wins; a lone request always wins.
  always_comb begin
    win     = (req0 & req1) ? ~last_q : req1;
    win_din = win ? din1 : din0;
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
`ifdef SREG_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = SHIFT;
          shreg_d = win_din;
          cnt_d   = '0;
          gnt_d   = win;
          last_d  = win;
          ack0_d  = ~win;
          ack1_d  = win;
`ifdef SREG_PARITY_EN
          par_d   = ^win_din;
`endif
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          if (cnt_q == CNT_LAST) begin
`ifdef SREG_PARITY_EN
            state_d = PAR;
`else
            state_d = IDLE;
`endif
          end else begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
`ifdef SREG_PARITY_EN
      PAR: begin
        if (ser_ready) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
`ifdef SREG_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
`ifdef SREG_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    ack0      = ack0_q;
    ack1      = ack1_q;
    gnt_id    = gnt_q;
    busy      = (state_q != IDLE);
    ser_valid = (state_q != IDLE);
    ser_out   = 1'b0;
    ser_first = (state_q == SHIFT) && (cnt_q == '0);
`ifdef SREG_PARITY_EN
    ser_last  = (state_q == PAR);
    if (state_q == PAR) ser_out = par_q;
`else
    ser_last  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
`endif
    if (state_q == SHIFT) ser_out = shreg_q[WIDTH-1];
  end

endmodule

// File: tb/tb_sreg_tx_arbiter.sv
// Self-checking bench for sreg_tx_arbiter: directed scenarios plus randomized traffic
// compared against a frame-level reference model (bit queue per granted word).
`timescale 1ns/1ps
module tb_sreg_tx_arbiter;
  localparam int unsigned W = 4;
`ifdef SREG_PARITY_EN
  localparam int unsigned FL = W + 1;
`else
  localparam int unsigned FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0, ser_ready = 1'b1;
  logic [W-1:0] din0 = '0, din1 = '0;
  logic         ack0, ack1, ser_out, ser_valid, ser_first, ser_last, busy, gnt_id;
  logic [7:0]   obs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sreg_tx_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .din0(din0), .req1(req1), .din1(din1),
    .ack0(ack0), .ack1(ack1),
    .ser_out(ser_out), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .ser_first(ser_first), .ser_last(ser_last),
    .busy(busy), .gnt_id(gnt_id)
  );

  assign obs = {ack0, ack1, busy, gnt_id, ser_valid, ser_out, ser_first, ser_last};

  // Reference model: a granted word becomes a queue of bits to emit.
  logic        m_bits[$];
  bit          m_busy, m_last, m_gnt, m_ack0, m_ack1;
  int unsigned m_pos;

  function automatic void model_reset();
    m_bits.delete();
    m_busy = 0; m_last = 1; m_gnt = 0; m_ack0 = 0; m_ack1 = 0; m_pos = 0;
  endfunction

  function automatic void model_edge();
    logic [W-1:0] word;
    bit w;
    m_ack0 = 0;
    m_ack1 = 0;
    if (!m_busy) begin
      if (req0 || req1) begin
        w = (req0 && req1) ? !m_last : req1;
        m_last = w;
        m_gnt  = w;
        if (w) m_ack1 = 1; else m_ack0 = 1;
        word = w ? din1 : din0;
        m_bits.delete();
        for (int i = W - 1; i >= 0; i--) m_bits.push_back(word[i]);
        if (FL > W) m_bits.push_back(^word);
        m_busy = 1;
        m_pos  = 0;
      end
    end else if (ser_ready) begin
      m_pos++;
      if (m_pos == FL) m_busy = 0;
    end
  endfunction

  function automatic logic [7:0] model_vec();
    logic o;
    o = m_busy ? m_bits[m_pos] : 1'b0;
    return {m_ack0, m_ack1, m_busy, m_gnt, m_busy, o,
            m_busy && (m_pos == 0), m_busy && (m_pos == FL - 1)};
  endfunction

  task automatic clk_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0; ser_ready = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs actual=%b expected=%b", obs, 8'h00);
    end
    @(negedge clk);
    rst = 1;
    clk_step();
    checks++;
    if (obs !== 8'h00) begin
      failures++;
      $display("FAIL idle_after_reset actual=%b expected=%b", obs, 8'h00);
    end
  endtask

  task automatic test_single();
    logic [W-1:0] word;
    logic [4:0]   e, a;
    logic         eo;
    do_reset();
    word = 4'b1010;
    din0 = word; req0 = 1;
    for (int c = 0; c < FL; c++) begin
      clk_step();
      eo = (c < W) ? word[W-1-c] : ^word;
      e = {c == 0, 1'b1, eo, c == 0, c == FL - 1};
      a = {ack0, ser_valid, ser_out, ser_first, ser_last};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL single_bit%0d {ack0,valid,out,first,last} actual=%b expected=%b", c, a, e);
      end
      if (c == 0) req0 = 0;
    end
    clk_step();
    checks++;
    if ({busy, ser_valid, ack0} !== 3'b000) begin
      failures++;
      $display("FAIL single_end {busy,valid,ack0} actual=%b expected=000", {busy, ser_valid, ack0});
    end
  endtask

  task automatic test_alternate();
    logic [W-1:0] word;
    logic [3:0]   e, a;
    req0 = 1; req1 = 1; ser_ready = 1;
    din0 = 4'b1100; din1 = 4'b0011;
    @(negedge clk);
    rst = 0;
    model_reset();
    @(negedge clk);
    rst = 1;
    for (int f = 0; f < 4; f++) begin
      word = (f % 2 == 1) ? din1 : din0;
      for (int c = 0; c < FL; c++) begin
        clk_step();
        e = {(c == 0) && (f % 2 == 0), (c == 0) && (f % 2 == 1), f % 2 == 1,
             (c < W) ? word[W-1-c] : ^word};
        a = {ack0, ack1, gnt_id, ser_out};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL alt_frame%0d_bit%0d {ack0,ack1,gnt,out} actual=%b expected=%b", f, c, a, e);
        end
      end
      clk_step();
      checks++;
      if ({busy, ack0, ack1} !== 3'b000) begin
        failures++;
        $display("FAIL alt_idle%0d {busy,ack0,ack1} actual=%b expected=000", f, {busy, ack0, ack1});
      end
    end
    req0 = 0; req1 = 0;
  endtask

  task automatic test_backpressure();
    logic [6:0] eo;
    logic [3:0] e, a;
    do_reset();
    eo = 7'b1000011;
    din0 = 4'b1011; req0 = 1;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) clk_step();
      e = {1'b1, eo[6-c], c == 0, (c == 6) && (FL == W)};
      a = {ser_valid, ser_out, ser_first, ser_last};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL bp_cycle%0d {valid,out,first,last} actual=%b expected=%b", c, a, e);
      end
      if (c == 0) req0 = 0;
      ser_ready = !(c >= 1 && c <= 3);
      if (c < 6) clk_step();
    end
    clk_step();
    if (FL > W) clk_step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_end busy actual=%b expected=0", busy);
    end
  endtask

  task automatic test_midframe();
    logic [4:0] a;
    do_reset();
    din0 = 4'b0110; req0 = 1;
    clk_step();
    req0 = 0;
    clk_step();
    din1 = 4'b1101; req1 = 1;
    for (int k = 0; k < FL - 1; k++) begin
      clk_step();
      checks++;
      if ({ack1, gnt_id} !== 2'b00) begin
        failures++;
        $display("FAIL mid_wait%0d {ack1,gnt} actual=%b expected=00", k, {ack1, gnt_id});
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_idle busy actual=%b expected=0", busy);
    end
    clk_step();
    a = {ack1, gnt_id, ser_valid, ser_out, ser_first};
    checks++;
    if (a !== 5'b11111) begin
      failures++;
      $display("FAIL mid_grant {ack1,gnt,valid,out,first} actual=%b expected=11111", a);
    end
    req1 = 0;
  endtask

  task automatic test_async_reset();
    logic [3:0] e, a;
    do_reset();
    din0 = 4'b1011; req0 = 1;
    clk_step();
    req0 = 0;
    din1 = 4'b0101; req1 = 1;
    clk_step();
    clk_step();
    #3;
    rst = 0;
    model_reset();
    #1;
    checks++;
    if (obs !== 8'h00) begin
      failures++;
      $display("FAIL async_reset_outputs actual=%b expected=%b", obs, 8'h00);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 8'h00) begin
      failures++;
      $display("FAIL reset_held_outputs actual=%b expected=%b", obs, 8'h00);
    end
    @(negedge clk);
    rst = 1;
    for (int c = 0; c < W; c++) begin
      clk_step();
      e = {c == 0, 1'b0, 1'b1, din1[W-1-c]};
      a = {ack1, ack0, gnt_id, ser_out};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL post_reset_bit%0d {ack1,ack0,gnt,out} actual=%b expected=%b", c, a, e);
      end
      if (c == 0) req1 = 0;
    end
  endtask

`ifdef SREG_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] words [2];
    logic [4:0]   exp_bits [2];
    logic [2:0]   e, a;
    words[0] = 4'b1011; exp_bits[0] = 5'b10111;
    words[1] = 4'b1001; exp_bits[1] = 5'b10010;
    for (int n = 0; n < 2; n++) begin
      do_reset();
      din0 = words[n]; req0 = 1;
      for (int c = 0; c < 5; c++) begin
        clk_step();
        e = {exp_bits[n][4-c], c == 0, c == 4};
        a = {ser_out, ser_first, ser_last};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL parity_w%0d_bit%0d {out,first,last} actual=%b expected=%b", n, c, a, e);
        end
        if (c == 0) req0 = 0;
      end
      clk_step();
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL parity_end%0d busy actual=%b expected=0", n, busy);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (!req0 && ($urandom % 3 == 0)) begin req0 = 1; din0 = W'($urandom); end
      else if (req0 && ($urandom % 50 == 0)) req0 = 0;
      if (!req1 && ($urandom % 3 == 0)) begin req1 = 1; din1 = W'($urandom); end
      else if (req1 && ($urandom % 50 == 0)) req1 = 0;
      ser_ready = ($urandom % 4) != 0;
      clk_step();
      e = model_vec();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL random_cycle%0d {ack0,ack1,busy,gnt,valid,out,first,last} actual=%b expected=%b",
                 i, obs, e);
      end
      if (m_ack0) req0 = 0;
      if (m_ack1) req1 = 0;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_midframe();
    test_async_reset();
`ifdef SREG_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
